// File: rtl/rf_multiport_sb.sv
// Multi-port register file (NUM_RD comb reads, ALU + load write ports) with a write-back busy scoreboard.
// Reads are zero-latency with optional same-cycle write bypass; writes and busy bits update on the clock edge.
module rf_multiport_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_busy,
   input  logic                       wa_en,
   input  logic [ADDR_W-1:0]          wa_addr,
   input  logic [DATA_W-1:0]          wa_data,
   input  logic                       wb_en,
   input  logic [ADDR_W-1:0]          wb_addr,
   input  logic [DATA_W-1:0]          wb_data,
   input  logic                       iss_en,
   input  logic [ADDR_W-1:0]          iss_addr,
   output logic [(2**ADDR_W)-1:0]     busy_vec
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] regs;
   logic                         wa_we;
   logic                         wb_we;
   logic [DEPTH-1:0]             set_vec;
   logic [DEPTH-1:0]             clr_vec;

   assign wa_we = wa_en && !((ZERO_REG != 0) && (wa_addr == '0));
   assign wb_we = wb_en && !((ZERO_REG != 0) && (wb_addr == '0));

   // Port B is written last so it wins an address collision with port A.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs <= '0;
      end else begin
         if (wa_we)
            regs[wa_addr] <= wa_data;
         if (wb_we)
            regs[wb_addr] <= wb_data;
      end
   end

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (iss_en)
         set_vec[iss_addr] = 1'b1;
      if (ZERO_REG != 0)
         set_vec[0] = 1'b0;
      if (wa_en)
         clr_vec[wa_addr] = 1'b1;
      if (wb_en)
         clr_vec[wb_addr] = 1'b1;
   end

   // A new producer at issue overrides a retiring one in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         busy_vec <= '0;
      else
         busy_vec <= set_vec | (busy_vec & ~clr_vec);
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              wa_hit;
      logic              wb_hit;
      logic              zero_hit;

      assign ra       = rd_addr[i*ADDR_W +: ADDR_W];
      assign wa_hit   = (BYPASS != 0) && wa_en && (wa_addr == ra);
      assign wb_hit   = (BYPASS != 0) && wb_en && (wb_addr == ra);
      assign zero_hit = (ZERO_REG != 0) && (ra == '0);

      assign rd_data[i*DATA_W +: DATA_W] = zero_hit ? '0      :
                                           wb_hit   ? wb_data :
                                           wa_hit   ? wa_data :
                                                      regs[ra];
      assign rd_busy[i] = !(wa_hit || wb_hit) && busy_vec[ra];
   end

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Bench for rf_multiport_sb: bypassing and non-bypassing instances share stimulus and are checked
// against an array-based model, with directed scenarios followed by randomized traffic.
module tb_rf_multiport_sb;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int DEPTH = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR*AW-1:0]  rd_addr;
   logic [NR*DW-1:0]  rd_data_b, rd_data_n;
   logic [NR-1:0]     rd_busy_b, rd_busy_n;
   logic              wa_en, wb_en, iss_en;
   logic [AW-1:0]     wa_addr, wb_addr, iss_addr;
   logic [DW-1:0]     wa_data, wb_data;
   logic [DEPTH-1:0]  busy_vec_b, busy_vec_n;

   rf_multiport_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) u_byp (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec_b));

   rf_multiport_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) u_nob (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
      .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec_n));

   always #5 clk = ~clk;

   int vecs = 0;
   int miss = 0;

   logic [DW-1:0]    m_reg [DEPTH];
   logic [DEPTH-1:0] m_busy;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int n = 0; n < DEPTH; n++) m_reg[n] = '0;
      m_busy = '0;
   endtask

   // Clears first, then issue, so an issue in the same cycle leaves the register busy.
   task automatic model_commit();
      if (wa_en && wa_addr != 0) m_reg[wa_addr] = wa_data;
      if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
      if (wa_en) m_busy[wa_addr] = 1'b0;
      if (wb_en) m_busy[wb_addr] = 1'b0;
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
   endtask

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
      logic [DW-1:0] d;
      if (a == 0) return '0;
      d = m_reg[a];
      if (byp && wa_en && wa_addr == a) d = wa_data;
      if (byp && wb_en && wb_addr == a) d = wb_data;
      return d;
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
      if (byp && ((wa_en && wa_addr == a) || (wb_en && wb_addr == a))) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic check_all(input string tag);
      for (int i = 0; i < NR; i++) begin
         logic [AW-1:0] a;
         a = rd_addr[i*AW +: AW];
         chk($sformatf("%s_p%0d_data_byp", tag, i), 64'(rd_data_b[i*DW +: DW]), 64'(exp_rd(a, 1'b1)));
         chk($sformatf("%s_p%0d_data_nob", tag, i), 64'(rd_data_n[i*DW +: DW]), 64'(exp_rd(a, 1'b0)));
         chk($sformatf("%s_p%0d_busy_byp", tag, i), 64'(rd_busy_b[i]), 64'(exp_busy(a, 1'b1)));
         chk($sformatf("%s_p%0d_busy_nob", tag, i), 64'(rd_busy_n[i]), 64'(exp_busy(a, 1'b0)));
      end
      chk({tag, "_busyvec_byp"}, 64'(busy_vec_b), 64'(m_busy));
      chk({tag, "_busyvec_nob"}, 64'(busy_vec_n), 64'(m_busy));
   endtask

   task automatic idle();
      wa_en = 1'b0; wa_addr = '0; wa_data = '0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      iss_en = 1'b0; iss_addr = '0;
   endtask

   task automatic at_neg(input string tag);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) model_commit();
      #1;
   endtask

   initial begin
      idle();
      rd_addr = '0;
      rst = 1'b1;
      model_reset();
      #2 check_all("rst_init");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Fill registers, mark reg 7 busy, then pulse reset mid-cycle
      for (int n = 1; n < DEPTH; n++) begin
         wa_en = 1'b1; wa_addr = AW'(n); wa_data = 32'hA5A5_0000 + n;
         rd_addr = {AW'(n), AW'(n - 1)};
         at_neg("t1_fill");
         tick();
      end
      idle();
      iss_en = 1'b1; iss_addr = 5'd7;
      at_neg("t1_iss");
      tick();
      idle();
      rd_addr = {5'd7, 5'd20};
      at_neg("t1_pre");
      chk("t1_pre_reg20", 64'(rd_data_b[31:0]), 64'h0000_0000_A5A5_0014);
      chk("t1_pre_busy7", 64'(busy_vec_b[7]), 64'd1);
      rst = 1'b1;
      model_reset();
      #1 check_all("t1_rst_a");
      chk("t1_rst_busyvec", 64'(busy_vec_b), 64'd0);
      rd_addr = {5'd31, 5'd1};
      #1 check_all("t1_rst_b");
      chk("t1_rst_reg1", 64'(rd_data_b[31:0]), 64'd0);
      #1 rst = 1'b0;
      tick();

      // Zero register ignores writes and issues
      wa_en = 1'b1; wa_addr = '0; wa_data = 32'hDEAD_BEEF;
      iss_en = 1'b1; iss_addr = '0;
      rd_addr = '0;
      at_neg("t2_same");
      chk("t2_same_r0", 64'(rd_data_b[31:0]), 64'd0);
      tick();
      idle();
      at_neg("t2_after");
      chk("t2_after_r0", 64'(rd_data_b[31:0]), 64'd0);
      chk("t2_after_busy0", 64'(busy_vec_b[0]), 64'd0);
      tick();

      // Write collision: port B wins
      wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h1111_1111;
      wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h2222_2222;
      rd_addr = {5'd0, 5'd5};
      at_neg("t3_byp");
      chk("t3_byp_r5", 64'(rd_data_b[31:0]), 64'h2222_2222);
      tick();
      idle();
      at_neg("t3_reg");
      chk("t3_reg_r5", 64'(rd_data_n[31:0]), 64'h2222_2222);
      tick();

      // Bypass versus registered-only read
      wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h10;
      at_neg("t4_init");
      tick();
      wa_data = 32'h20;
      rd_addr = {5'd0, 5'd3};
      at_neg("t4_same");
      chk("t4_same_byp", 64'(rd_data_b[31:0]), 64'h20);
      chk("t4_same_nob", 64'(rd_data_n[31:0]), 64'h10);
      tick();
      idle();
      at_neg("t4_after");
      chk("t4_after_nob", 64'(rd_data_n[31:0]), 64'h20);
      tick();

      // Scoreboard set at issue, cleared at write-back
      iss_en = 1'b1; iss_addr = 5'd9;
      rd_addr = {5'd0, 5'd9};
      at_neg("t5_c0");
      tick();
      idle();
      at_neg("t5_c1");
      chk("t5_c1_busy9", 64'(busy_vec_b[9]), 64'd1);
      tick();
      at_neg("t5_c2");
      tick();
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h0909_0909;
      at_neg("t5_c3");
      chk("t5_c3_rdbusy_byp", 64'(rd_busy_b[0]), 64'd0);
      chk("t5_c3_rdbusy_nob", 64'(rd_busy_n[0]), 64'd1);
      tick();
      idle();
      at_neg("t5_c4");
      chk("t5_c4_busy9", 64'(busy_vec_b[9]), 64'd0);
      tick();

      // Issue and write-back to the same register in one cycle
      iss_en = 1'b1; iss_addr = 5'd12;
      at_neg("t6_iss");
      tick();
      wa_en = 1'b1; wa_addr = 5'd12; wa_data = 32'hC0FF_EE12;
      rd_addr = {5'd0, 5'd12};
      at_neg("t6_race");
      tick();
      idle();
      at_neg("t6_after");
      chk("t6_after_busy12", 64'(busy_vec_b[12]), 64'd1);
      chk("t6_after_r12", 64'(rd_data_n[31:0]), 64'hC0FF_EE12);
      tick();

      // Randomized traffic; a narrow address window forces frequent collisions
      for (int c = 0; c < 400; c++) begin
         int hi;
         hi = ($urandom_range(0, 1) == 1) ? 3 : 31;
         wa_en = 1'($urandom_range(0, 1));
         wa_addr = AW'($urandom_range(0, hi));
         wa_data = $urandom;
         wb_en = 1'($urandom_range(0, 1));
         wb_addr = AW'($urandom_range(0, hi));
         wb_data = $urandom;
         iss_en = 1'($urandom_range(0, 1));
         iss_addr = AW'($urandom_range(0, hi));
         rd_addr = {AW'($urandom_range(0, hi)), AW'($urandom_range(0, hi))};
         at_neg("rnd");
         tick();
      end
      idle();
      at_neg("final");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
